input_conditioner: RTL and testbench

Conditions the three raw player push-buttons (left, right, jump) before they reach the game physics stage. Each button is synchronised and debounced. Left/right become a movement direction. The jump button runs a charge-and-release state machine: holding jump builds jump power, and release delivers a jump request to physics through a valid/ack handshake. The block sits between the board pins and the player-physics logic inside `top_debug`.

---
 rtl/input_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 58 +++++
 rtl/input_conditioner.sv | 170 +++++++++++++++++
 tb/tb_input_conditioner.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// ----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the player input conditioner and the physics stage.
//   state_t      : jump FSM states (IDLE / CHARGE / FIRE)
//   MOVE_*       : move_dir encodings, also decoded by player physics
//   move_encode  : debounced left/right to move_dir, both pressed gives none
// ----------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FIRE   = 2'd2
    } state_t;

    localparam logic [1:0] MOVE_NONE  = 2'b00;
    localparam logic [1:0] MOVE_LEFT  = 2'b01;
    localparam logic [1:0] MOVE_RIGHT = 2'b10;

    function automatic logic [1:0] move_encode(input logic left_db, input logic right_db);
        logic [1:0] dir;
        case ({left_db, right_db})
            2'b10:   dir = MOVE_LEFT;
            2'b01:   dir = MOVE_RIGHT;
            default: dir = MOVE_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a counting debouncer for one button.
// The stable state only flips after the synchronised level has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
//   sys_clk  in  system clock
//   sys_rst  in  asynchronous active-high reset
//   btn_raw  in  raw asynchronous button level (1 = pressed)
//   btn_db   out debounced level, registered
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_db = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
// Debounces the left/right/jump buttons, derives the movement direction and
// runs the jump charge-and-release FSM that hands a jump request to physics.
//   sys_clk       in   system clock
//   sys_rst       in   asynchronous active-high reset
//   left/right/jump in raw button levels (1 = pressed)
//   airborne      in   player not on ground (gates movement, aborts charge)
//   jump_ack      in   physics accepts the pending jump request (FIRE only)
//   move_dir      out  MOVE_NONE / MOVE_LEFT / MOVE_RIGHT
//   charging      out  1 while charging a jump
//   charge_level  out  live charge for the HUD
//   jump_valid    out  jump request pending
//   jump_power    out  latched power, stable while jump_valid is high
// ----------------------------------------------------------------------------
module input_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int CHARGE_STEP_CYCLES = 8,
    parameter int CHARGE_MAX         = 63,
    parameter int CHARGE_W           = 6
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                left,
    input  logic                right,
    input  logic                jump,
    input  logic                airborne,
    input  logic                jump_ack,
    output logic [1:0]          move_dir,
    output logic                charging,
    output logic [CHARGE_W-1:0] charge_level,
    output logic                jump_valid,
    output logic [CHARGE_W-1:0] jump_power
);

    // Window after reset during which the debouncers may still be catching up
    // with a button that was already held.
    localparam int SETTLE = DEBOUNCE_CYCLES + 2;
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SETTLE);

    localparam int STEP_W = (CHARGE_STEP_CYCLES > 1) ? $clog2(CHARGE_STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(CHARGE_STEP_CYCLES - 1);
    localparam logic [CHARGE_W-1:0] LVL_MAX   = CHARGE_W'(CHARGE_MAX);
    localparam logic [CHARGE_W-1:0] LVL_ONE   = CHARGE_W'(1);

    logic [2:0] btn_raw;
    logic [2:0] btn_db;
    logic       left_db;
    logic       right_db;
    logic       jump_db;

    assign btn_raw = {jump, right, left};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .sys_clk(sys_clk),
                .sys_rst(sys_rst),
                .btn_raw(btn_raw[gi]),
                .btn_db (btn_db[gi])
            );
        end
    endgenerate

    assign left_db  = btn_db[0];
    assign right_db = btn_db[1];
    assign jump_db  = btn_db[2];

    state_t              state_q;
    logic [SET_W-1:0]    settle_q;
    logic                armed_q;
    logic                jump_prev_q;
    logic [STEP_W-1:0]   step_q;
    logic [CHARGE_W-1:0] level_q;
    logic [CHARGE_W-1:0] power_q;
    logic                valid_q;
    logic                charging_q;
    logic [1:0]          move_q;

    logic settled;
    logic jump_rise;
    logic jump_fall;

    assign settled   = (settle_q == SETTLE_DONE);
    // Rising edges only count once the debounced jump has been seen released
    // after settling, so a button held through reset never starts a charge.
    assign jump_rise = armed_q & jump_db & ~jump_prev_q;
    assign jump_fall = ~jump_db & jump_prev_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            jump_prev_q <= 1'b0;
            step_q      <= '0;
            level_q     <= '0;
            power_q     <= '0;
            valid_q     <= 1'b0;
            charging_q  <= 1'b0;
            move_q      <= MOVE_NONE;
        end else begin
            jump_prev_q <= jump_db;
            if (!settled) begin
                settle_q <= settle_q + 1'b1;
            end
            if (settled && !jump_db) begin
                armed_q <= 1'b1;
            end

            move_q <= (state_q == ST_IDLE && !airborne) ? move_encode(left_db, right_db)
                                                        : MOVE_NONE;

            case (state_q)
                ST_IDLE: begin
                    if (jump_rise && !airborne) begin
                        state_q    <= ST_CHARGE;
                        level_q    <= '0;
                        step_q     <= '0;
                        charging_q <= 1'b1;
                    end
                end
                ST_CHARGE: begin
                    // Abort beats release, release beats the step increment.
                    if (airborne) begin
                        state_q    <= ST_IDLE;
                        level_q    <= '0;
                        charging_q <= 1'b0;
                    end else if (jump_fall) begin
                        state_q    <= ST_FIRE;
                        power_q    <= (level_q == '0) ? LVL_ONE : level_q;
                        valid_q    <= 1'b1;
                        charging_q <= 1'b0;
                    end else if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        if (level_q != LVL_MAX) begin
                            level_q <= level_q + 1'b1;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (jump_ack) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        level_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    valid_q    <= 1'b0;
                    charging_q <= 1'b0;
                end
            endcase
        end
    end

    assign move_dir     = move_q;
    assign charging     = charging_q;
    assign charge_level = level_q;
    assign jump_valid   = valid_q;
    assign jump_power   = power_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       jump = 1'b0;
    logic       airborne = 1'b0;
    logic       jump_ack = 1'b0;
    logic [1:0] move_dir;
    logic       charging;
    logic [5:0] charge_level;
    logic       jump_valid;
    logic [5:0] jump_power;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES   (4),
        .CHARGE_STEP_CYCLES(8),
        .CHARGE_MAX        (63),
        .CHARGE_W          (6)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .left        (left),
        .right       (right),
        .jump        (jump),
        .airborne    (airborne),
        .jump_ack    (jump_ack),
        .move_dir    (move_dir),
        .charging    (charging),
        .charge_level(charge_level),
        .jump_valid  (jump_valid),
        .jump_power  (jump_power)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_charging(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (charging === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Press, hold for m cycles after charging is seen, release; the FSM then
    // spends m+6 cycles in CHARGE before seeing the debounced release.
    task automatic do_charge(input int m, input int exp_pow, input string tag);
        bit ok;
        jump = 1'b1;
        wait_charging(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_enter: charging=%b required 1 within 30 cycles", tag, charging);
        end
        tick(m);
        jump = 1'b0;
        tick(6);
        n_checks++;
        if (jump_valid !== 1'b0 || charging !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pre_fire: valid=%b charging=%b required valid=0 charging=1",
                     tag, jump_valid, charging);
        end
        tick(1);
        n_checks++;
        if (jump_valid !== 1'b1 || jump_power !== 6'(exp_pow) || charging !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_fire: valid=%b power=%0d charging=%b required valid=1 power=%0d charging=0",
                     tag, jump_valid, jump_power, charging, exp_pow);
        end
        $display("txn %s: charge cycles=%0d power=%0d expected=%0d", tag, m + 6, jump_power, exp_pow);
    endtask

    task automatic do_ack(input int delay, input int exp_pow, input string tag);
        tick(delay);
        n_checks++;
        if (jump_valid !== 1'b1 || jump_power !== 6'(exp_pow)) begin
            n_fail++;
            $display("FAIL %s_hold: valid=%b power=%0d required valid=1 power=%0d",
                     tag, jump_valid, jump_power, exp_pow);
        end
        jump_ack = 1'b1;
        tick(1);
        jump_ack = 1'b0;
        n_checks++;
        if (jump_valid !== 1'b0 || charge_level !== 6'd0 || charging !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack: valid=%b level=%0d charging=%b required 0/0/0",
                     tag, jump_valid, charge_level, charging);
        end
        $display("txn %s_ack: valid=%b level=%0d", tag, jump_valid, charge_level);
        tick(2);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(2);
        n_checks++;
        if ({move_dir, charging, charge_level, jump_valid, jump_power} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h required 0", {move_dir, charging, charge_level, jump_valid, jump_power});
        end
        sys_rst = 1'b0;
        tick(12);
        n_checks++;
        if ({move_dir, charging, charge_level, jump_valid, jump_power} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%h required 0", {move_dir, charging, charge_level, jump_valid, jump_power});
        end
        $display("txn reset: outputs=%h", {move_dir, charging, charge_level, jump_valid, jump_power});
    endtask

    task automatic test_bounce();
        bit glitch = 1'b0;
        bit early  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jump = ~jump;
            tick(1);
            if (charging !== 1'b0 || dut.jump_db !== 1'b0) glitch = 1'b1;
            tick(1);
            if (charging !== 1'b0 || dut.jump_db !== 1'b0) glitch = 1'b1;
        end
        n_checks++;
        if (glitch) begin
            n_fail++;
            $display("FAIL bounce_glitch: debounced jump or charging rose during bouncing");
        end
        jump = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (dut.jump_db !== 1'b0 || charging !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL bounce_early: debounced jump rose before 6 cycles");
        end
        tick(1);
        n_checks++;
        if (dut.jump_db !== 1'b1 || charging !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_db6: jump_db=%b charging=%b required 1/0", dut.jump_db, charging);
        end
        tick(1);
        n_checks++;
        if (charging !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_charge7: charging=%b required 1", charging);
        end
        $display("txn bounce: jump_db=%b charging=%b", dut.jump_db, charging);
        // Finish this charge: held 7 cycles so far plus 6 more debounce cycles.
        tick(1);
        jump = 1'b0;
        tick(7);
        n_checks++;
        if (jump_valid !== 1'b1 || jump_power !== 6'd1) begin
            n_fail++;
            $display("FAIL bounce_fire: valid=%b power=%0d required 1/1", jump_valid, jump_power);
        end
        do_ack(1, 1, "bounce");
    endtask

    task automatic test_normal_charge();
        bit ok;
        jump = 1'b1;
        wait_charging(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL normal_enter: charging never rose");
        end
        tick(34);
        n_checks++;
        if (charge_level !== 6'd4) begin
            n_fail++;
            $display("FAIL normal_level34: level=%0d required 4", charge_level);
        end
        tick(60);
        jump = 1'b0;
        tick(6);
        n_checks++;
        if (charge_level !== 6'd12 || jump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_level100: level=%0d valid=%b required 12/0", charge_level, jump_valid);
        end
        tick(1);
        n_checks++;
        if (jump_valid !== 1'b1 || jump_power !== 6'd12) begin
            n_fail++;
            $display("FAIL normal_fire: valid=%b power=%0d required 1/12", jump_valid, jump_power);
        end
        $display("txn normal: power=%0d valid=%b", jump_power, jump_valid);
        do_ack(5, 12, "normal");
    endtask

    task automatic test_saturation_tap();
        do_charge(994, 63, "saturate");
        do_ack(2, 63, "saturate");
        do_charge(0, 1, "tap");
        do_ack(2, 1, "tap");
    endtask

    task automatic test_abort();
        bit ok;
        bit bad = 1'b0;
        jump = 1'b1;
        wait_charging(ok);
        tick(40);
        n_checks++;
        if (!ok || charge_level !== 6'd5) begin
            n_fail++;
            $display("FAIL abort_level40: entered=%b level=%0d required 1/5", ok, charge_level);
        end
        airborne = 1'b1;
        tick(1);
        n_checks++;
        if (charging !== 1'b0 || charge_level !== 6'd0) begin
            n_fail++;
            $display("FAIL abort_exit: charging=%b level=%0d required 0/0", charging, charge_level);
        end
        jump = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (jump_valid !== 1'b0 || charging !== 1'b0) bad = 1'b1;
        end
        airborne = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (jump_valid !== 1'b0 || charging !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_release: a request or charge appeared after abort");
        end
        $display("txn abort: charging=%b valid=%b level=%0d", charging, jump_valid, charge_level);
    endtask

    task automatic test_movement();
        bit ok;
        left = 1'b1;
        tick(8);
        n_checks++;
        if (move_dir !== 2'b01) begin
            n_fail++;
            $display("FAIL move_left: move_dir=%b required 01", move_dir);
        end
        right = 1'b1;
        tick(8);
        n_checks++;
        if (move_dir !== 2'b00) begin
            n_fail++;
            $display("FAIL move_both: move_dir=%b required 00", move_dir);
        end
        left = 1'b0;
        tick(8);
        n_checks++;
        if (move_dir !== 2'b10) begin
            n_fail++;
            $display("FAIL move_right: move_dir=%b required 10", move_dir);
        end
        jump = 1'b1;
        wait_charging(ok);
        tick(1);
        n_checks++;
        if (!ok || move_dir !== 2'b00) begin
            n_fail++;
            $display("FAIL move_charging: entered=%b move_dir=%b required 1/00", ok, move_dir);
        end
        jump = 1'b0;
        tick(7);
        do_ack(1, 1, "move");
        tick(2);
        airborne = 1'b1;
        tick(2);
        n_checks++;
        if (move_dir !== 2'b00) begin
            n_fail++;
            $display("FAIL move_airborne: move_dir=%b required 00", move_dir);
        end
        airborne = 1'b0;
        tick(2);
        n_checks++;
        if (move_dir !== 2'b10) begin
            n_fail++;
            $display("FAIL move_landed: move_dir=%b required 10", move_dir);
        end
        right = 1'b0;
        tick(8);
        $display("txn movement: move_dir=%b", move_dir);
    endtask

    task automatic test_reset_mid_fire();
        bit ok;
        bit bad = 1'b0;
        jump = 1'b1;
        wait_charging(ok);
        tick(10);
        jump = 1'b0;
        tick(7);
        n_checks++;
        if (!ok || jump_valid !== 1'b1 || jump_power !== 6'd2) begin
            n_fail++;
            $display("FAIL rstfire_fire: valid=%b power=%0d required 1/2", jump_valid, jump_power);
        end
        jump = 1'b1;
        tick(3);
        #2 sys_rst = 1'b1;
        #1;
        n_checks++;
        if ({move_dir, charging, charge_level, jump_valid, jump_power} !== 16'd0) begin
            n_fail++;
            $display("FAIL rstfire_async: outputs=%h required 0", {move_dir, charging, charge_level, jump_valid, jump_power});
        end
        tick(2);
        sys_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (charging !== 1'b0 || jump_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rstfire_retrigger: held jump started a charge after reset");
        end
        jump = 1'b0;
        tick(12);
        jump = 1'b1;
        wait_charging(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstfire_fresh: fresh press did not start a charge");
        end
        $display("txn reset_mid_fire: fresh_press_charging=%b", charging);
        jump = 1'b0;
        tick(7);
        do_ack(1, 1, "rstfire");
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_normal_charge();
        test_saturation_tap();
        test_abort();
        test_movement();
        test_reset_mid_fire();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
